exe_mem_req_agent: RTL

// - Execute-stage data-memory request agent for the SRAM-like bus (req/addr_ok/data_ok).
// - Takes one load/store per handshake; computes byte strobes, lane-replicated wdata and the aligned address.
// - Holds req stable until addr_ok and tracks up to MAX_OUT outstanding transactions.
// - On pipeline flush, discards data_ok responses that belong to cancelled transactions.

---
 rtl/exe_mem_req_agent_if.sv | 27 ++
 rtl/exe_mem_req_agent.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_req_agent_if.sv
// exe_mem_req_agent_if: SRAM-like data bus (req/addr_ok/data_ok) between the
// execute-stage request agent (master) and the memory side (slave).
interface exe_mem_req_agent_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [NB-1:0]     wstrb;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok
    );
endinterface

// File: rtl/exe_mem_req_agent.sv
// exe_mem_req_agent: execute-stage data-memory request agent.
// Accepts one load/store per handshake, formats strobes/data/address for the
// SRAM-like bus, holds req until addr_ok, counts outstanding transactions and
// drops data_ok responses that belong to transactions cancelled by a flush.
// Optional feature: define EXE_MEM_ALE_EN to turn size-misaligned accesses into
// a one-cycle address-error pulse instead of a bus request.
module exe_mem_req_agent #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MAX_OUT = 2,
    localparam int NB     = DATA_W / 8,
    localparam int CW     = $clog2(MAX_OUT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_store,
    input  logic [1:0]          in_size,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic                flush,
    exe_mem_req_agent_if.master bus,
    output logic                resp_valid,
    output logic                ale_valid,
    output logic [ADDR_W-1:0]   ale_badv,
    output logic [CW-1:0]       outstanding
);
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, CANCEL} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NB-1:0]     wstrb_q, wstrb_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic              accept;
    logic              inc;
    logic              dec;
    logic              dead_hs;
    logic [OFFW-1:0]   low_mask;
    logic [7:0]        ones;
    logic [NB-1:0]     strb_new;
    logic [DATA_W-1:0] wdata_new;
    logic [ADDR_W-1:0] addr_new;

`ifdef EXE_MEM_ALE_EN
    logic              misaligned;
    logic              ale_pend_q, ale_pend_d;
    logic [ADDR_W-1:0] ale_badv_q, ale_badv_d;
`endif

    assign in_ready = (state_q == IDLE) && (outstanding_q < CW'(MAX_OUT)) && !flush;
    assign accept   = in_valid && in_ready;
    assign dec      = bus.data_ok && (outstanding_q != '0);
    assign addr_new = {in_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};

    // Format the incoming request: strobe run of 2^size bytes at the size-aligned lane, replicated data
    always_comb begin
        low_mask  = '0;
        ones      = 8'h00;
        wdata_new = in_wdata;
        case (in_size)
            2'd0: begin
                low_mask  = '0;
                ones      = 8'h01;
                wdata_new = {NB{in_wdata[7:0]}};
            end
            2'd1: begin
                low_mask  = OFFW'(1);
                ones      = 8'h03;
                wdata_new = {(NB/2){in_wdata[15:0]}};
            end
            2'd2: begin
                low_mask  = OFFW'(3);
                ones      = 8'h0F;
                wdata_new = {(NB/4){in_wdata[31:0]}};
            end
            default: begin
                low_mask  = '1;
                ones      = 8'hFF;
                wdata_new = in_wdata;
            end
        endcase
        strb_new = NB'(ones) << (in_addr[OFFW-1:0] & ~low_mask);
    end

`ifdef EXE_MEM_ALE_EN
    // Detect an address that is not a multiple of the access size
    always_comb begin
        case (in_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = in_addr[0];
            2'd2:    misaligned = |in_addr[1:0];
            default: misaligned = |in_addr[2:0];
        endcase
    end
`endif

    // Next-state logic: request FSM, outstanding counter and flush discard bookkeeping
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        wr_d          = wr_q;
        size_d        = size_q;
        addr_d        = addr_q;
        wstrb_d       = wstrb_q;
        wdata_d       = wdata_q;
        inc           = 1'b0;
        dead_hs       = 1'b0;
`ifdef EXE_MEM_ALE_EN
        ale_pend_d    = 1'b0;
        ale_badv_d    = ale_badv_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef EXE_MEM_ALE_EN
                    if (misaligned) begin
                        ale_pend_d = 1'b1;
                        ale_badv_d = in_addr;
                    end else begin
`else
                    begin
`endif
                        req_d   = 1'b1;
                        wr_d    = in_store;
                        size_d  = in_size;
                        addr_d  = addr_new;
                        wstrb_d = in_store ? strb_new : '0;
                        wdata_d = wdata_new;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) begin
                    wstrb_d = '0;
                end
                if (bus.addr_ok) begin
                    inc     = 1'b1;
                    dead_hs = flush;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = CANCEL;
                end
            end
            CANCEL: begin
                if (bus.addr_ok) begin
                    inc     = 1'b1;
                    dead_hs = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        outstanding_d = outstanding_q + CW'(inc) - CW'(dec);
        // A flush condemns everything still in flight, including a handshake
        // completing in this same cycle (REQ or CANCEL alike).
        if (flush) begin
            discard_d = outstanding_q - CW'(dec) + CW'(dead_hs);
        end else begin
            discard_d = discard_q - CW'(dec && (discard_q != '0)) + CW'(dead_hs);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            wr_q          <= 1'b0;
            size_q        <= 2'd0;
            addr_q        <= '0;
            wstrb_q       <= '0;
            wdata_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
`ifdef EXE_MEM_ALE_EN
            ale_pend_q    <= 1'b0;
            ale_badv_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            wr_q          <= wr_d;
            size_q        <= size_d;
            addr_q        <= addr_d;
            wstrb_q       <= wstrb_d;
            wdata_q       <= wdata_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
`ifdef EXE_MEM_ALE_EN
            ale_pend_q    <= ale_pend_d;
            ale_badv_q    <= ale_badv_d;
`endif
        end
    end

    assign bus.req     = req_q;
    assign bus.wr      = wr_q;
    assign bus.size    = size_q;
    assign bus.addr    = addr_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wdata   = wdata_q;
    assign outstanding = outstanding_q;
    assign resp_valid  = dec && (discard_q == '0);

`ifdef EXE_MEM_ALE_EN
    assign ale_valid = ale_pend_q && !flush;
    assign ale_badv  = ale_badv_q;
`else
    assign ale_valid = 1'b0;
    assign ale_badv  = '0;
`endif

    // A response with nothing outstanding means the bus broke its protocol
    assert property (@(posedge clk) disable iff (reset) bus.data_ok |-> (outstanding_q != '0));

endmodule
